// File: rtl/rec_play_sequencer.sv
// Record/playback sequencer for the single-port sample BRAM: decimated capture while
// record_in is high, looped playback of the recorded samples while it is low.
module rec_play_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DECIM  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              record_in,
    input  logic              ready_in,
    input  logic [DATA_W-1:0] mic_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   len_out,
    output logic              full_out,
    output logic [1:0]        state_out
);

    localparam int unsigned DcntW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DcntW-1:0]  DcntLast = DcntW'(DECIM - 1);
    localparam logic [ADDR_W:0]   LenFull  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
    localparam logic [DcntW-1:0]  DcntOne  = DcntW'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRec  = 2'd1,
        StPlay = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              full_q, full_d;
    logic [DcntW-1:0]  dcnt_q, dcnt_d;
    logic [DcntW-1:0]  dcnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] data_q, data_d;
    // Bit k set: a read was issued k+1 clocks ago; bit RD_LAT means bram_dout is valid now.
    logic [RD_LAT:0]   pipe_q, pipe_d;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (record_in) state_d = StRec;
            end
            StRec: begin
                if (!record_in) state_d = (len_q == '0) ? StIdle : StPlay;
            end
            StPlay: begin
                if (record_in) state_d = StRec;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dcnt_inc = (dcnt_q == DcntLast) ? '0 : dcnt_q + DcntOne;

    // Datapath next-state; a strobe arriving in a mode-change cycle is dropped
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        full_d   = full_q;
        dcnt_d   = dcnt_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        din_d    = din_q;
        data_d   = data_q;
        pipe_d   = {pipe_q[RD_LAT-1:0], 1'b0};

        if (state_d != state_q) begin
            pipe_d = '0;
            if (state_d == StRec) begin
                wr_ptr_d = '0;
                len_d    = '0;
                full_d   = 1'b0;
                dcnt_d   = '0;
            end else if (state_d == StPlay) begin
                rd_ptr_d = '0;
                dcnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ready_in) data_d = mic_in;
                end
                StRec: begin
                    if (ready_in) begin
                        data_d = mic_in;
                        dcnt_d = dcnt_inc;
                        if (dcnt_q == '0 && !full_q) begin
                            we_d     = 1'b1;
                            addr_d   = wr_ptr_q;
                            din_d    = mic_in;
                            wr_ptr_d = wr_ptr_q + PtrOne;
                            len_d    = len_q + LenOne;
                            full_d   = ((len_q + LenOne) == LenFull);
                        end
                    end
                end
                StPlay: begin
                    if (pipe_q[RD_LAT]) data_d = bram_dout;
                    if (ready_in) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_q == '0) begin
                            addr_d    = rd_ptr_q;
                            pipe_d[0] = 1'b1;
                            rd_ptr_d  = ({1'b0, rd_ptr_q} == (len_q - LenOne)) ? '0
                                                                               : rd_ptr_q + PtrOne;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            full_q   <= 1'b0;
            dcnt_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            din_q    <= '0;
            data_q   <= '0;
            pipe_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            full_q   <= full_d;
            dcnt_q   <= dcnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            din_q    <= din_d;
            data_q   <= data_d;
            pipe_q   <= pipe_d;
        end
    end

    assign bram_addr = addr_q;
    assign bram_we   = we_q;
    assign bram_din  = din_q;
    assign data_out  = data_q;
    assign len_out   = len_q;
    assign full_out  = full_q;
    assign state_out = state_q;

endmodule
